// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin, packet-locked arbiter for one mesh router output port.
// Flit codes fall back to local defaults when include/parameters.sv is not part of the build.
`ifndef HEADER
`define HEADER 3'd1
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'd2
`endif
`ifndef TAIL
`define TAIL 3'd3
`endif

module output_port_arbiter #(
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IN-1:0]   req,
    input  logic [NUM_IN-1:0]   empty,
    input  logic [3*NUM_IN-1:0] flit_id_in,
    input  logic                credit_avail,
    output logic [NUM_IN-1:0]   grant,
    output logic [NUM_IN-1:0]   read_en,
    output logic [SEL_W-1:0]    xbar_sel,
    output logic                valid_out,
    output logic                busy
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nx;
    logic [NUM_IN-1:0] elig, grant_nx;
    logic [SEL_W-1:0] rr_ptr, rr_nx, sel_nx, win, idx;
    logic [2:0] owner_id;
    logic found, xfer;
    always_comb begin
        elig = '0;
        owner_id = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            elig[i] = req[i] & ~empty[i] & (flit_id_in[3*i +: 3] == `HEADER);
            if (xbar_sel == SEL_W'(i)) owner_id = flit_id_in[3*i +: 3];
        end
        found = 1'b0;
        win = '0;
        idx = '0;
        // scan starts just past the last winner, wrapping modulo NUM_IN
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    assign xfer = (state == LOCKED) & ~empty[xbar_sel] & credit_avail;
    assign read_en = xfer ? grant : '0;
    assign valid_out = xfer;
    assign busy = (state == LOCKED);
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        sel_nx = xbar_sel;
        rr_nx = rr_ptr;
        if (state == IDLE && found) begin
            state_nx = LOCKED;
            grant_nx = NUM_IN'(1) << win;
            sel_nx = win;
            rr_nx = win;
        end else if (state == LOCKED && xfer && owner_id == `TAIL) begin
            state_nx = IDLE;
            grant_nx = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            xbar_sel <= '0;
            rr_ptr <= SEL_W'(NUM_IN - 1);
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            xbar_sel <= sel_nx;
            rr_ptr <= rr_nx;
        end
    end
endmodule
